// File: rtl/spi_host.sv
// Mode-0 SPI host issuing 16-bit register read/write frames.
// Each frame is SHIFT, then HOLD (ss still low), then an inter-frame GAP with ss high.
module spi_host #(
  parameter int CLKDIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       rnw,
  input  logic [3:0] addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       busy,
  output logic       done,
  output logic       ss,
  output logic       sclk,
  output logic       mosi,
  input  logic       miso
);

  // state | meaning
  // IDLE  | waiting for start, ss high
  // SHIFT | 16 sclk periods, mosi driven and miso sampled
  // HOLD  | sclk low, ss still low, for CLKDIV cycles
  // GAP   | ss high, busy still high, for CLKDIV cycles
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;
  localparam logic [1:0] GAP   = 2'd3;

  localparam logic [15:0] DIV_M1 = 16'(CLKDIV - 1);

  logic [1:0]  state;
  logic [15:0] cnt;
  logic [3:0]  bitcnt;
  logic [14:0] sreg;     // frame bits 14:0; bit 15 is driven onto mosi directly at acceptance
  logic [7:0]  rx;
  logic        rnw_q;
  logic        just_idle;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      bitcnt    <= '0;
      sreg      <= '0;
      rx        <= '0;
      rnw_q     <= 1'b0;
      just_idle <= 1'b0;
      rdata     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      ss        <= 1'b1;
      sclk      <= 1'b0;
      mosi      <= 1'b0;
    end else begin
      done      <= 1'b0;
      just_idle <= 1'b0;
      case (state)
        IDLE: begin
          // A start arriving in the cycle busy falls is dropped, not held over.
          if (start && !just_idle) begin
            sreg   <= {3'b000, addr, (rnw ? 8'h00 : wdata)};
            rnw_q  <= rnw;
            mosi   <= rnw;
            ss     <= 1'b0;
            busy   <= 1'b1;
            cnt    <= DIV_M1;
            bitcnt <= '0;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          if (cnt == 16'd0) begin
            cnt <= DIV_M1;
            if (!sclk) begin
              sclk <= 1'b1;
              rx   <= {rx[6:0], miso};
            end else begin
              sclk <= 1'b0;
              if (bitcnt == 4'd15) begin
                mosi  <= 1'b0;
                state <= HOLD;
              end else begin
                bitcnt <= bitcnt + 4'd1;
                mosi   <= sreg[14];
                sreg   <= {sreg[13:0], 1'b0};
              end
            end
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        HOLD: begin
          if (cnt == 16'd0) begin
            ss    <= 1'b1;
            done  <= 1'b1;
            cnt   <= DIV_M1;
            state <= GAP;
            if (rnw_q) rdata <= rx;
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        default: begin
          if (cnt == 16'd0) begin
            busy      <= 1'b0;
            just_idle <= 1'b1;
            state     <= IDLE;
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_host.sv
// Directed bench for spi_host: instance A with CLKDIV=2, instance B with CLKDIV=1.
// Protocol monitors on both instances accumulate violations checked at the end.
module tb_spi_host;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       start_a, rnw_a, miso_a;
  logic [3:0] addr_a;
  logic [7:0] wdata_a, rdata_a;
  logic       busy_a, done_a, ss_a, sclk_a, mosi_a;

  logic       start_b, rnw_b, miso_b;
  logic [3:0] addr_b;
  logic [7:0] wdata_b, rdata_b;
  logic       busy_b, done_b, ss_b, sclk_b, mosi_b;

  spi_host #(.CLKDIV(2)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .rnw(rnw_a), .addr(addr_a), .wdata(wdata_a),
    .rdata(rdata_a), .busy(busy_a), .done(done_a), .ss(ss_a), .sclk(sclk_a),
    .mosi(mosi_a), .miso(miso_a)
  );

  spi_host #(.CLKDIV(1)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .rnw(rnw_b), .addr(addr_b), .wdata(wdata_b),
    .rdata(rdata_b), .busy(busy_b), .done(done_b), .ss(ss_b), .sclk(sclk_b),
    .mosi(mosi_b), .miso(miso_b)
  );

  int total = 0;
  int bad   = 0;

  // monitor + slave model, instance A
  logic [7:0]  slave_byte = 8'h00;
  logic [15:0] frame_a = '0;
  int rises_a = 0, falls_a = 0, perr_a = 0;
  logic p_sclk_a = 1'b0, p_mosi_a = 1'b0, p_ss_a = 1'b1;

  always @(negedge clk) begin
    if (ss_a && sclk_a) perr_a++;
    if (done_a && !ss_a) perr_a++;
    if (p_sclk_a && sclk_a && (mosi_a !== p_mosi_a)) perr_a++;
    if (p_ss_a && !ss_a) begin
      rises_a = 0; falls_a = 0; frame_a = '0;
    end
    if (!p_sclk_a && sclk_a) begin
      rises_a++;
      frame_a = {frame_a[14:0], mosi_a};
    end
    if (p_sclk_a && !sclk_a) falls_a++;
    if (done_a && (rises_a != 16 || falls_a != 16)) perr_a++;
    if (!sclk_a) miso_a = (rises_a >= 8 && rises_a < 16) ? slave_byte[15 - rises_a] : 1'b0;
    p_sclk_a = sclk_a; p_mosi_a = mosi_a; p_ss_a = ss_a;
  end

  // monitor, instance B (miso tied high)
  logic [15:0] frame_b = '0;
  int rises_b = 0, falls_b = 0, perr_b = 0;
  logic p_sclk_b = 1'b0, p_mosi_b = 1'b0, p_ss_b = 1'b1;

  always @(negedge clk) begin
    if (ss_b && sclk_b) perr_b++;
    if (done_b && !ss_b) perr_b++;
    if (p_sclk_b && sclk_b && (mosi_b !== p_mosi_b)) perr_b++;
    if (p_ss_b && !ss_b) begin
      rises_b = 0; falls_b = 0; frame_b = '0;
    end
    if (!p_sclk_b && sclk_b) begin
      rises_b++;
      frame_b = {frame_b[14:0], mosi_b};
    end
    if (p_sclk_b && !sclk_b) falls_b++;
    if (done_b && (rises_b != 16 || falls_b != 16)) perr_b++;
    p_sclk_b = sclk_b; p_mosi_b = mosi_b; p_ss_b = ss_b;
  end

  task automatic test_reset();
    rst = 1'b1;
    start_a = 1'b1; rnw_a = 1'b0; addr_a = 4'h7; wdata_a = 8'hFF;
    start_b = 1'b0; rnw_b = 1'b0; addr_b = 4'h0; wdata_b = 8'h00; miso_b = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (ss_a !== 1'b1)     begin bad++; $display("FAIL reset_ss got=%b exp=1", ss_a); end
    total++; if (sclk_a !== 1'b0)   begin bad++; $display("FAIL reset_sclk got=%b exp=0", sclk_a); end
    total++; if (mosi_a !== 1'b0)   begin bad++; $display("FAIL reset_mosi got=%b exp=0", mosi_a); end
    total++; if (busy_a !== 1'b0)   begin bad++; $display("FAIL reset_busy got=%b exp=0", busy_a); end
    total++; if (done_a !== 1'b0)   begin bad++; $display("FAIL reset_done got=%b exp=0", done_a); end
    total++; if (rdata_a !== 8'h00) begin bad++; $display("FAIL reset_rdata got=%h exp=00", rdata_a); end
    total++; if (ss_b !== 1'b1)     begin bad++; $display("FAIL reset_ss_b got=%b exp=1", ss_b); end
    start_a = 1'b0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_read();
    logic [7:0] exp_rd;
    slave_byte = 8'hA5;
    @(negedge clk);
    start_a = 1'b1; rnw_a = 1'b1; addr_a = 4'h1; wdata_a = 8'h77;
    for (int rel = 1; rel <= 70; rel++) begin
      @(negedge clk);
      if (rel == 1) begin
        start_a = 1'b0; rnw_a = 1'b0; addr_a = 4'hE; wdata_a = 8'hC3;
      end
      exp_rd = (rel >= 67) ? 8'hA5 : 8'h00;
      total++; if (ss_a !== ((rel >= 1 && rel <= 66) ? 1'b0 : 1'b1)) begin bad++; $display("FAIL rd_ss rel=%0d got=%b", rel, ss_a); end
      total++; if (sclk_a !== ((rel <= 64) ? 1'(((rel - 1) / 2) % 2) : 1'b0)) begin bad++; $display("FAIL rd_sclk rel=%0d got=%b", rel, sclk_a); end
      total++; if (done_a !== (rel == 67)) begin bad++; $display("FAIL rd_done rel=%0d got=%b", rel, done_a); end
      total++; if (busy_a !== (rel <= 68)) begin bad++; $display("FAIL rd_busy rel=%0d got=%b", rel, busy_a); end
      total++; if (rdata_a !== exp_rd) begin bad++; $display("FAIL rd_rdata rel=%0d got=%h exp=%h", rel, rdata_a, exp_rd); end
      if (rel == 67) begin
        total++; if (frame_a !== 16'h8100) begin bad++; $display("FAIL rd_frame got=%h exp=8100", frame_a); end
      end
    end
  endtask

  task automatic test_write();
    @(negedge clk);
    start_a = 1'b1; rnw_a = 1'b0; addr_a = 4'h0; wdata_a = 8'h80;
    for (int rel = 1; rel <= 70; rel++) begin
      @(negedge clk);
      if (rel == 1) begin
        start_a = 1'b0; rnw_a = 1'b1; addr_a = 4'hF; wdata_a = 8'h01;
      end
      total++; if (ss_a !== ((rel <= 66) ? 1'b0 : 1'b1)) begin bad++; $display("FAIL wr_ss rel=%0d got=%b", rel, ss_a); end
      total++; if (done_a !== (rel == 67)) begin bad++; $display("FAIL wr_done rel=%0d got=%b", rel, done_a); end
      total++; if (busy_a !== (rel <= 68)) begin bad++; $display("FAIL wr_busy rel=%0d got=%b", rel, busy_a); end
      total++; if (rdata_a !== 8'hA5) begin bad++; $display("FAIL wr_rdata rel=%0d got=%h exp=a5", rel, rdata_a); end
      if (rel == 67) begin
        total++; if (frame_a !== 16'h0080) begin bad++; $display("FAIL wr_frame got=%h exp=0080", frame_a); end
      end
    end
  endtask

  task automatic test_busy_reject();
    int ndone = 0;
    @(negedge clk);
    start_a = 1'b1; rnw_a = 1'b0; addr_a = 4'h2; wdata_a = 8'h3C;
    for (int rel = 1; rel <= 140; rel++) begin
      @(negedge clk);
      start_a = (rel == 10 || rel == 69 || rel == 70);
      if (rel == 69) begin
        rnw_a = 1'b0; addr_a = 4'h5; wdata_a = 8'h11;
      end
      if (rel <= 70 && done_a) ndone++;
      if (rel == 11) begin
        total++; if (ss_a !== 1'b0) begin bad++; $display("FAIL br_ss11 got=%b exp=0", ss_a); end
      end
      if (rel == 67) begin
        total++; if (frame_a !== 16'h023C) begin bad++; $display("FAIL br_frame1 got=%h exp=023c", frame_a); end
      end
      if (rel == 70) begin
        total++; if (ss_a !== 1'b1) begin bad++; $display("FAIL br_ss70 got=%b exp=1", ss_a); end
        total++; if (ndone != 1) begin bad++; $display("FAIL br_ndone got=%0d exp=1", ndone); end
      end
      if (rel == 71) begin
        total++; if (ss_a !== 1'b0) begin bad++; $display("FAIL br_ss71 got=%b exp=0", ss_a); end
      end
      if (rel == 137) begin
        total++; if (done_a !== 1'b1) begin bad++; $display("FAIL br_done2 got=%b exp=1", done_a); end
        total++; if (frame_a !== 16'h0511) begin bad++; $display("FAIL br_frame2 got=%h exp=0511", frame_a); end
      end
    end
    start_a = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset_abort();
    int ndone = 0;
    slave_byte = 8'h3C;
    @(negedge clk);
    start_a = 1'b1; rnw_a = 1'b1; addr_a = 4'h4; wdata_a = 8'h00;
    for (int rel = 1; rel <= 92; rel++) begin
      @(negedge clk);
      if (rel == 1) start_a = 1'b0;
      if (rel == 20) rst = 1'b1;
      if (rel >= 21 && rel <= 87 && done_a) ndone++;
      if (rel == 21) begin
        total++; if (ss_a !== 1'b1)     begin bad++; $display("FAIL ab_ss got=%b exp=1", ss_a); end
        total++; if (sclk_a !== 1'b0)   begin bad++; $display("FAIL ab_sclk got=%b exp=0", sclk_a); end
        total++; if (busy_a !== 1'b0)   begin bad++; $display("FAIL ab_busy got=%b exp=0", busy_a); end
        total++; if (rdata_a !== 8'h00) begin bad++; $display("FAIL ab_rdata got=%h exp=00", rdata_a); end
        rst = 1'b0;
        start_a = 1'b1; rnw_a = 1'b0; addr_a = 4'h3; wdata_a = 8'h5A;
      end
      if (rel == 22) begin
        start_a = 1'b0;
        total++; if (ss_a !== 1'b0) begin bad++; $display("FAIL ab_restart_ss got=%b exp=0", ss_a); end
      end
      if (rel == 88) begin
        total++; if (ndone != 0) begin bad++; $display("FAIL ab_nodone got=%0d exp=0", ndone); end
        total++; if (done_a !== 1'b1) begin bad++; $display("FAIL ab_done got=%b exp=1", done_a); end
        total++; if (frame_a !== 16'h035A) begin bad++; $display("FAIL ab_frame got=%h exp=035a", frame_a); end
        total++; if (rdata_a !== 8'h00) begin bad++; $display("FAIL ab_rdata_wr got=%h exp=00", rdata_a); end
      end
    end
  endtask

  task automatic test_clkdiv1();
    @(negedge clk);
    start_b = 1'b1; rnw_b = 1'b1; addr_b = 4'hF; wdata_b = 8'h99;
    for (int rel = 1; rel <= 37; rel++) begin
      @(negedge clk);
      if (rel == 1) start_b = 1'b0;
      total++; if (ss_b !== ((rel <= 33) ? 1'b0 : 1'b1)) begin bad++; $display("FAIL d1_ss rel=%0d got=%b", rel, ss_b); end
      total++; if (sclk_b !== ((rel <= 32) ? 1'((rel - 1) % 2) : 1'b0)) begin bad++; $display("FAIL d1_sclk rel=%0d got=%b", rel, sclk_b); end
      total++; if (done_b !== (rel == 34)) begin bad++; $display("FAIL d1_done rel=%0d got=%b", rel, done_b); end
      total++; if (busy_b !== (rel <= 34)) begin bad++; $display("FAIL d1_busy rel=%0d got=%b", rel, busy_b); end
      if (rel == 34) begin
        total++; if (rdata_b !== 8'hFF)     begin bad++; $display("FAIL d1_rdata got=%h exp=ff", rdata_b); end
        total++; if (frame_b !== 16'h8F00)  begin bad++; $display("FAIL d1_frame got=%h exp=8f00", frame_b); end
        total++; if (rises_b != 16)         begin bad++; $display("FAIL d1_rises got=%0d exp=16", rises_b); end
      end
    end
  endtask

  task automatic test_protocol();
    total++; if (perr_a != 0) begin bad++; $display("FAIL proto_a violations=%0d exp=0", perr_a); end
    total++; if (perr_b != 0) begin bad++; $display("FAIL proto_b violations=%0d exp=0", perr_b); end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_busy_reject();
    test_reset_abort();
    test_clkdiv1();
    test_protocol();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
